data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory behind a valid/ready request/response handshake with a fixed wait latency.
// Optional feature: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_byte_sel,
    input  logic        req_sign_ext,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         WORDS     = 2 ** (ADDR_WIDTH - 2);
    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_ERR_EN = 1'b1;
`else
    localparam bit MIS_ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            sel_q, sel_d;
    logic                  sext_q, sext_d;

    logic                  accept;
    logic                  mem_fire;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [1:0]            acc_sel;
    logic                  acc_mis;
    logic [IDX_W-1:0]      mem_idx;
    logic [3:0]            lane_we;
    logic [31:0]           lane_wdata;
    logic [31:0]           rd_word;
    logic                  resp_mis;
    logic                  unused_addr_hi;

    function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] sel);
        logic raw;
        case (sel)
            2'b00:   raw = 1'b0;
            2'b01:   raw = lo[0];
            default: raw = (lo != 2'b00);
        endcase
        misaligned = MIS_ERR_EN && raw;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [1:0] sel);
        case (sel)
            2'b00:   align_addr = a;
            2'b01:   align_addr = {a[ADDR_WIDTH-1:1], 1'b0};
            default: align_addr = {a[ADDR_WIDTH-1:2], 2'b00};
        endcase
    endfunction

    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];
    assign accept         = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            sel_q   <= 2'b00;
            sext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            sext_q  <= sext_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        sext_d   = sext_q;
        mem_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata;
                    sel_d   = req_byte_sel;
                    sext_d  = req_sign_ext;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = ST_RESP;
                        mem_fire = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    mem_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait the memory is touched on the accepting edge, before the request is latched.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr[ADDR_WIDTH-1:0];
            acc_wdata = req_wdata;
            acc_sel   = req_byte_sel;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_sel   = sel_q;
        end
    end

    assign acc_mis = misaligned(acc_addr[1:0], acc_sel);
    assign mem_idx = align_addr(acc_addr, acc_sel) >> 2;

    always_comb begin
        case (acc_sel)
            2'b00: begin
                lane_wdata = {4{acc_wdata[7:0]}};
                lane_we    = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{acc_wdata[15:0]}};
                lane_we    = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = acc_wdata;
                lane_we    = 4'b1111;
            end
        endcase
        if (!acc_we || acc_mis) lane_we = 4'b0000;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] rd_byte_q;
            always_ff @(posedge clk) begin
                if (mem_fire) begin
                    if (lane_we[gi]) lane_mem[mem_idx] <= lane_wdata[8*gi +: 8];
                    rd_byte_q <= lane_mem[mem_idx];
                end
            end
            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

    assign resp_mis = misaligned(addr_q[1:0], sel_q);

    // Read data is held in the lane registers for the whole RESP state, so the response stays stable.
    always_comb begin
        req_ready = rst && (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid && resp_mis;
        rsp_rdata = 32'd0;
        if (rsp_valid && !we_q && !resp_mis) begin
            case (sel_q)
                2'b00: begin
                    case (addr_q[1:0])
                        2'd0:    rsp_rdata[7:0] = rd_word[7:0];
                        2'd1:    rsp_rdata[7:0] = rd_word[15:8];
                        2'd2:    rsp_rdata[7:0] = rd_word[23:16];
                        default: rsp_rdata[7:0] = rd_word[31:24];
                    endcase
                    rsp_rdata[31:8] = {24{sext_q & rsp_rdata[7]}};
                end
                2'b01: begin
                    rsp_rdata[15:0]  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
                    rsp_rdata[31:16] = {16{sext_q & rsp_rdata[15]}};
                end
                default: rsp_rdata = rd_word;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: handshake latency, byte lanes, extension, backpressure and reset abort.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_byte_sel;
    logic        req_sign_ext;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_byte_sel (req_byte_sel),
        .req_sign_ext (req_sign_ext),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full request/response; hold > 0 keeps rsp_ready low that many cycles and
    // meanwhile presents a stray store that must be ignored.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] sel, input logic sext,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int          n;
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_byte_sel = sel;
        req_sign_ext = sext;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_0BAD;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, ".latency"}, 32'(lat), 32'd3);
        check_val({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check_val({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid    = 1'b1;
            req_we       = 1'b1;
            req_addr     = 32'h0000_0010;
            req_wdata    = 32'h0;
            req_byte_sel = 2'b10;
            @(posedge clk);
            #1;
            check_val({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check_val({tag, ".hold_rdata"}, rsp_rdata, held);
            check_val({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
        check_val({tag, ".valid_after"}, {31'd0, rsp_valid}, 32'd0);
        $display("xact %s we=%0d addr=0x%08h wdata=0x%08h sel=%0d sext=%0d rdata=0x%08h err=%0d lat=%0d",
                 tag, we, addr, wdata, sel, sext, held, exp_err, lat);
    endtask

    initial begin
        logic [31:0] mis_data;
        logic        mis_err;

        rst          = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h10;
        req_wdata    = 32'h5555_5555;
        req_byte_sel = 2'b10;
        req_sign_ext = 1'b0;
        rsp_ready    = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("rst.req_ready", {31'd0, req_ready}, 32'd0);
            check_val("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check_val("rst.rsp_rdata", rsp_rdata, 32'd0);
            check_val("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check_val("rst.release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_val("rst.idle_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst.idle_valid", {31'd0, rsp_valid}, 32'd0);
        $display("xact reset released");

        xact("st_word", 1'b1, 32'h010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_word", 1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
        xact("ld_byte_s", 1'b0, 32'h011, 32'h0, 2'b00, 1'b1, 32'hFFFF_FFBE, 1'b0, 0);
        xact("ld_byte_z", 1'b0, 32'h011, 32'h0, 2'b00, 1'b0, 32'h0000_00BE, 1'b0, 0);
        xact("backpress", 1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 5);

        xact("st_prior", 1'b1, 32'h020, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h020;
        req_wdata    = 32'h1234_5678;
        req_byte_sel = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_val("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("abort.req_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        $display("xact reset during store wait");
        xact("ld_abort", 1'b0, 32'h020, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 0);

`ifdef DMEM_MISALIGN_ERR_EN
        mis_data = 32'h0;
        mis_err  = 1'b1;
`else
        mis_data = 32'hDEAD_BEEF;
        mis_err  = 1'b0;
`endif
        xact("ld_misalign", 1'b0, 32'h013, 32'h0, 2'b10, 1'b0, mis_data, mis_err, 0);

        xact("st_byte", 1'b1, 32'h012, 32'h0000_007F, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_after_b", 1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 32'hDE7F_BEEF, 1'b0, 0);
        xact("ld_half_s", 1'b0, 32'h012, 32'h0, 2'b01, 1'b1, 32'hFFFF_DE7F, 1'b0, 0);
        xact("ld_half_z", 1'b0, 32'h010, 32'h0, 2'b01, 1'b0, 32'h0000_BEEF, 1'b0, 0);
        xact("st_half_wrap", 1'b1, 32'hFFFF_F022, 32'hABCD_1234, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_after_h", 1'b0, 32'h020, 32'h0, 2'b10, 1'b0, 32'h1234_F00D, 1'b0, 0);
        xact("ld_wrap", 1'b0, 32'h1010, 32'h0, 2'b10, 1'b1, 32'hDE7F_BEEF, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
